instr_fetch_ctrl: RTL and testbench

Instruction fetch controller that sequences reads from the byte-addressed, little-endian instruction memory and buffers fetched words in a small prefetch FIFO for the decode stage. It sits between the PC/branch logic and the instruction ROM. It owns the fetch PC, issues one word request at a time over a req/ack port, handles redirects (branches, jumps) by flushing stale words, and halts with a sticky fault on a misaligned redirect target. An asynchronous ROM connects by tying imem_ack to imem_req, which gives one fetch per cycle.

---
 rtl/instr_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Owns the fetch PC and walks the instruction memory one word at a time
//   over a req/ack port. Fetched words (with their PC) are buffered in a
//   small prefetch FIFO for decode. A redirect flushes the FIFO and retargets
//   fetch; a misaligned redirect target raises a sticky fault and halts fetch
//   until reset.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_addr/req      word request to instruction memory (addr 4-aligned)
//   imem_ack/rdata     request completion and returned word
//   instr/instr_pc     FIFO head word and its PC
//   instr_valid/ready  decode handshake (pop on valid & ready)
//   redirect/_pc       load new fetch PC and flush buffered words
//   fault              sticky misaligned-redirect flag
module instr_fetch_ctrl #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DEPTH         = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic                     imem_req,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH_WAIT, HALT_WAIT, HALT} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    instr;
        logic [ADDRESS_WIDTH-1:0] pc;
    } entry_t;

    state_t                   state, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] saved_pc, saved_pc_d;
    logic                     pending;
    logic                     req, ack;
    logic                     flush, push, pop, set_fault;

    entry_t                   fifo_mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         count;

    // Head outputs come from FIFO storage and count only; zero when empty.
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_mem[rd_ptr].instr : '0;
    assign instr_pc    = instr_valid ? fifo_mem[rd_ptr].pc    : '0;
    assign imem_addr   = fetch_pc;
    // Drop the request the moment reset asserts, outstanding or not.
    assign imem_req    = req & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        saved_pc_d = saved_pc;
        flush      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        set_fault  = 1'b0;
        case (state)
            RUN:                   req = pending | (count < FULL);
            FLUSH_WAIT, HALT_WAIT: req = 1'b1;
            default:               req = 1'b0;
        endcase
        ack = req & imem_ack;

        if (redirect && (state == RUN || state == FLUSH_WAIT)) begin
            flush = 1'b1;
            if (redirect_pc[1:0] != 2'b00) begin
                set_fault = 1'b1;
                state_d   = (req && !imem_ack) ? HALT_WAIT : HALT;
            end else if (req && !imem_ack) begin
                // Request must stay stable until ack; park the target.
                saved_pc_d = redirect_pc;
                state_d    = FLUSH_WAIT;
            end else begin
                fetch_pc_d = redirect_pc;
                state_d    = RUN;
            end
        end else begin
            pop = instr_valid & instr_ready;
            case (state)
                RUN: begin
                    push = ack;
                    if (ack) fetch_pc_d = fetch_pc + ADDRESS_WIDTH'(4);
                end
                FLUSH_WAIT: begin
                    // Stale word is dropped; resume at the parked target.
                    if (ack) begin
                        fetch_pc_d = saved_pc;
                        state_d    = RUN;
                    end
                end
                HALT_WAIT: if (ack) state_d = HALT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            saved_pc <= RESET_PC;
            pending  <= 1'b0;
            fault    <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            fetch_pc <= fetch_pc_d;
            saved_pc <= saved_pc_d;
            pending  <= req & ~imem_ack;
            if (set_fault) fault <= 1'b1;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Payload storage needs no reset; reads are gated by instr_valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {imem_rdata, fetch_pc};
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl. ROM returns the byte address as the
// word; imem_ack is either tied to imem_req or driven by hand.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fault;

    logic ack_mode = 1'b1;
    logic ack_manual = 1'b0;
    int   checks = 0;
    int   passes = 0;

    assign imem_ack   = ack_mode ? imem_req : ack_manual;
    assign imem_rdata = imem_addr;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
    );

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ack_mode = 1'b1; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, instr_valid, fault, instr, instr_pc, imem_addr} !== {3'b000, 96'h0})
            $display("FAIL reset_vals: got req=%b v=%b f=%b i=%h pc=%h a=%h exp all 0",
                     imem_req, instr_valid, fault, instr, instr_pc, imem_addr);
        else passes++;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL first_req: got req=%b a=%h exp req=1 a=0", imem_req, imem_addr);
        else passes++;
    endtask

    task automatic test_stream;
        ack_mode = 1'b1; instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(4 * i), 32'(4 * i)})
                $display("FAIL stream[%0d]: got v=%b pc=%h i=%h exp v=1 pc=%h",
                         i, instr_valid, instr_pc, instr, 4 * i);
            else passes++;
        end
    endtask

    task automatic test_backpressure;
        ack_mode = 1'b1; instr_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        checks++;
        if ({instr_valid, instr_pc, imem_req} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL bp_full: got v=%b pc=%h req=%b exp v=1 pc=0 req=0",
                     instr_valid, instr_pc, imem_req);
        else passes++;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(4 * i), 32'(4 * i)})
                $display("FAIL bp_drain[%0d]: got v=%b pc=%h exp v=1 pc=%h",
                         i, instr_valid, instr_pc, 4 * i);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect;
        ack_mode = 1'b1; instr_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);      // head = 8, fetching 12
        instr_ready = 1'b0;
        @(negedge clk);                 // FIFO holds 8,12
        checks++;
        if ({instr_valid, instr_pc, imem_req} !== {1'b1, 32'h8, 1'b0})
            $display("FAIL redir_hold: got v=%b pc=%h req=%b exp v=1 pc=8 req=0",
                     instr_valid, instr_pc, imem_req);
        else passes++;
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0; instr_ready = 1'b1;
        checks++;
        if ({instr_valid, imem_addr, imem_req} !== {1'b0, 32'h40, 1'b1})
            $display("FAIL redir_flush: got v=%b a=%h req=%b exp v=0 a=40 req=1",
                     instr_valid, imem_addr, imem_req);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, instr_pc} !== {1'b1, 32'(32'h40 + 4 * i)})
                $display("FAIL redir_tgt[%0d]: got v=%b pc=%h exp v=1 pc=%h",
                         i, instr_valid, instr_pc, 32'h40 + 4 * i);
            else passes++;
        end
        // Redirect in a cycle where a fetch also completes: that word is dropped.
        redirect = 1'b1; redirect_pc = 32'h60;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({instr_valid, imem_addr} !== {1'b0, 32'h60})
            $display("FAIL redir_live: got v=%b a=%h exp v=0 a=60", instr_valid, imem_addr);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(32'h60 + 4 * i), 32'(32'h60 + 4 * i)})
                $display("FAIL redir_live_tgt[%0d]: got v=%b pc=%h exp v=1 pc=%h",
                         i, instr_valid, instr_pc, 32'h60 + 4 * i);
            else passes++;
        end
    endtask

    task automatic test_delayed_ack;
        ack_mode = 1'b0; ack_manual = 1'b0; instr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h80;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            redirect = 1'b0;
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0})
                $display("FAIL dack_hold[%0d]: got req=%b a=%h v=%b exp req=1 a=0 v=0",
                         i, imem_req, imem_addr, instr_valid);
            else passes++;
        end
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0; ack_mode = 1'b1;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h80, 1'b0})
            $display("FAIL dack_retarget: got req=%b a=%h v=%b exp req=1 a=80 v=0",
                     imem_req, imem_addr, instr_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h80, 32'h80})
            $display("FAIL dack_tgt: got v=%b pc=%h i=%h exp v=1 pc=80 i=80",
                     instr_valid, instr_pc, instr);
        else passes++;
    endtask

    task automatic test_misaligned;
        ack_mode = 1'b1; instr_ready = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);      // head 4, fetching 8
        redirect = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        redirect_pc = 32'h100;          // must be ignored from here on
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({fault, instr_valid, imem_req, imem_addr} !== {3'b100, 32'h8})
                $display("FAIL halt[%0d]: got f=%b v=%b req=%b a=%h exp f=1 v=0 req=0 a=8",
                         i, fault, instr_valid, imem_req, imem_addr);
            else passes++;
            @(negedge clk);
        end
        redirect = 1'b0;
    endtask

    task automatic test_reset_mid;
        ack_mode = 1'b1; instr_ready = 1'b0;
        do_reset();
        @(negedge clk);
        ack_mode = 1'b0; ack_manual = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_valid, instr_pc, imem_req, imem_addr} !== {1'b1, 32'h0, 1'b1, 32'h4})
            $display("FAIL mid_pend: got v=%b pc=%h req=%b a=%h exp v=1 pc=0 req=1 a=4",
                     instr_valid, instr_pc, imem_req, imem_addr);
        else passes++;
        redirect = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({fault, instr_valid, imem_req, imem_addr} !== {3'b101, 32'h4})
            $display("FAIL halt_wait: got f=%b v=%b req=%b a=%h exp f=1 v=0 req=1 a=4",
                     fault, instr_valid, imem_req, imem_addr);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, fault, instr, instr_pc, imem_addr} !== {3'b000, 96'h0})
            $display("FAIL mid_reset: got req=%b v=%b f=%b i=%h pc=%h a=%h exp all 0",
                     imem_req, instr_valid, fault, instr, instr_pc, imem_addr);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1; ack_mode = 1'b1; instr_ready = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, fault} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL restart: got req=%b a=%h f=%b exp req=1 a=0 f=0",
                     imem_req, imem_addr, fault);
        else passes++;
        @(negedge clk);
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h0})
            $display("FAIL restart_head: got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc);
        else passes++;
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        ack_mode = 1'b1; instr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc[i], exp_pc[i]})
                $display("FAIL wrap[%0d]: got v=%b pc=%h i=%h exp v=1 pc=%h",
                         i, instr_valid, instr_pc, instr, exp_pc[i]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_delayed_ack();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
